// File: rtl/interrupt_ctrl_v2.sv
// Memory-mapped interrupt controller: per-line enable and edge/level mode, sticky pending,
// fixed priority (line 0 highest) and a claim/complete handshake with no nesting.
module interrupt_ctrl_v2 #(
  parameter int unsigned NUM_LINES = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0410
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [15:0]          i_addr,
  input  logic [15:0]          i_data,
  output logic [15:0]          o_data,
  input  logic [NUM_LINES-1:0] i_lines,
  output logic                 o_int,
  output logic [4:0]           o_id
);

  typedef enum logic [1:0] {StIdle, StActive, StService} state_e;

  state_e               r_state;
  logic [NUM_LINES-1:0] r_enable, r_mode, r_pending, r_line_q;
  logic [4:0]           r_claimed_id, r_id;
  logic                 r_int;
  logic [15:0]          r_data;

  logic [15:0]          w_off;
  logic                 w_sel_en, w_sel_pend, w_sel_mode, w_sel_claim, w_sel_cmpl;
  logic [NUM_LINES-1:0] w_req, w_rise, w_clr, w_pending_d;
  logic [4:0]           w_enc;
  logic                 w_claim, w_complete;
  logic [15:0]          w_rdata;

  assign w_off       = i_addr - BASE_ADDR;
  assign w_sel_en    = (w_off == 16'd0);
  assign w_sel_pend  = (w_off == 16'd1);
  assign w_sel_mode  = (w_off == 16'd2);
  assign w_sel_claim = (w_off == 16'd3);
  assign w_sel_cmpl  = (w_off == 16'd4);

  assign w_req = r_pending & r_enable;

  // Descending scan so the lowest index is the last (winning) assignment.
  always_comb begin
    w_enc = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (w_req[i]) w_enc = 5'(i + 1);
    end
  end

  // A read that coincides with a write is treated as a write only: no claim side effect.
  assign w_claim    = i_re && !i_we && w_sel_claim && (r_state == StActive);
  assign w_complete = i_we && w_sel_cmpl && (r_state == StService) &&
                      (i_data[4:0] == r_claimed_id);

  always_comb begin
    w_clr = '0;
    if (i_we && w_sel_pend) w_clr = i_data[NUM_LINES-1:0];
    if (w_claim) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (5'(i + 1) == r_id) w_clr[i] = 1'b1;
      end
    end
  end

  // Edge bits latch rises (a new rise beats any clear); level bits simply follow the line.
  assign w_rise      = i_lines & ~r_line_q;
  assign w_pending_d = (r_mode & ((r_pending & ~w_clr) | w_rise)) | (~r_mode & i_lines);

  always_comb begin
    w_rdata = '0;
    if (w_sel_en)    w_rdata = 16'(r_enable);
    if (w_sel_pend)  w_rdata = 16'(r_pending);
    if (w_sel_mode)  w_rdata = 16'(r_mode);
    if (w_sel_claim) w_rdata = (r_state == StActive) ? 16'(r_id) : 16'd0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_enable  <= '0;
      r_mode    <= '0;
      r_pending <= '0;
      r_line_q  <= '0;
      r_id      <= '0;
      r_data    <= '0;
    end else begin
      if (i_we && w_sel_en)   r_enable <= i_data[NUM_LINES-1:0];
      if (i_we && w_sel_mode) r_mode   <= i_data[NUM_LINES-1:0];
      r_pending <= w_pending_d;
      r_line_q  <= i_lines;
      r_id      <= w_enc;
      r_data    <= (i_re && !i_we) ? w_rdata : 16'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= StIdle;
      r_int        <= 1'b0;
      r_claimed_id <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_req != '0) begin
            r_state <= StActive;
            r_int   <= 1'b1;
          end
        end
        StActive: begin
          if (w_claim) begin
            r_state      <= StService;
            r_int        <= 1'b0;
            r_claimed_id <= r_id;
          end else if (w_req == '0) begin
            r_state <= StIdle;
            r_int   <= 1'b0;
          end
        end
        StService: begin
          if (w_complete) r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_int   <= 1'b0;
        end
      endcase
    end
  end

  assign o_int  = r_int;
  assign o_id   = r_id;
  assign o_data = r_data;

endmodule

// File: tb/tb_interrupt_ctrl_v2.sv
// Bench for interrupt_ctrl_v2: directed scenarios with literal expectations plus random
// bus/line traffic, all checked every cycle against a behavioural model.
module tb_interrupt_ctrl_v2;

  localparam logic [15:0] BASE = 16'h0410;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_we = 1'b0, i_re = 1'b0;
  logic [15:0] i_addr = '0, i_data = '0, i_lines = '0;
  logic [15:0] o_data;
  logic        o_int;
  logic [4:0]  o_id;

  logic        we4 = 1'b0, re4 = 1'b0;
  logic [15:0] addr4 = '0, data4 = '0, odata4;
  logic [3:0]  lines4 = '0;
  logic        int4;
  logic [4:0]  id4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  interrupt_ctrl_v2 #(.NUM_LINES(16), .BASE_ADDR(BASE)) u_dut (
    .i_clk(clk), .i_rst(rst_n), .i_we(i_we), .i_re(i_re), .i_addr(i_addr), .i_data(i_data),
    .o_data(o_data), .i_lines(i_lines), .o_int(o_int), .o_id(o_id)
  );

  interrupt_ctrl_v2 #(.NUM_LINES(4), .BASE_ADDR(BASE)) u_dut4 (
    .i_clk(clk), .i_rst(rst_n), .i_we(we4), .i_re(re4), .i_addr(addr4), .i_data(data4),
    .o_data(odata4), .i_lines(lines4), .o_int(int4), .o_id(id4)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending bits, a "waiting for claim" flag and an "in service" flag.
  logic [15:0] m_en = '0, m_mode = '0, m_pend = '0, m_prev = '0, m_data = '0;
  logic [4:0]  m_id = '0, m_claimed = '0;
  logic        m_int = 1'b0, m_svc = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [15:0] req, newp, rd, off;
    logic [4:0]  lowest;
    logic        claim;
    if (!rst_n) begin
      m_en = '0; m_mode = '0; m_pend = '0; m_prev = '0; m_data = '0;
      m_id = '0; m_claimed = '0; m_int = 1'b0; m_svc = 1'b0;
    end else begin
      off = i_addr - BASE;
      req = m_pend & m_en;
      lowest = '0;
      for (int i = 15; i >= 0; i--) if (req[i]) lowest = 5'(i + 1);
      claim = i_re && !i_we && off == 16'd3 && m_int;
      rd = '0;
      if (i_re && !i_we) begin
        case (off)
          16'd0: rd = m_en;
          16'd1: rd = m_pend;
          16'd2: rd = m_mode;
          16'd3: rd = m_int ? 16'(m_id) : 16'd0;
          default: rd = '0;
        endcase
      end
      for (int i = 0; i < 16; i++) begin
        if (m_mode[i]) begin
          newp[i] = m_pend[i];
          if (i_we && off == 16'd1 && i_data[i]) newp[i] = 1'b0;
          if (claim && m_id == 5'(i + 1)) newp[i] = 1'b0;
          if (i_lines[i] && !m_prev[i]) newp[i] = 1'b1;
        end else begin
          newp[i] = i_lines[i];
        end
      end
      if (m_svc) begin
        if (i_we && off == 16'd4 && i_data[4:0] == m_claimed) m_svc = 1'b0;
      end else if (m_int) begin
        if (claim) begin
          m_svc = 1'b1; m_claimed = m_id; m_int = 1'b0;
        end else if (req == '0) begin
          m_int = 1'b0;
        end
      end else if (req != '0) begin
        m_int = 1'b1;
      end
      if (i_we && off == 16'd0) m_en = i_data;
      if (i_we && off == 16'd2) m_mode = i_data;
      m_id = lowest;
      m_data = rd;
      m_pend = newp;
      m_prev = i_lines;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("model_int", 16'(o_int), 16'(m_int));
      check("model_id", 16'(o_id), 16'(m_id));
      check("model_data", o_data, m_data);
    end
  end

  // Called at a negedge; return at a negedge.
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    i_we = 1'b1; i_addr = a; i_data = d;
    @(negedge clk);
    i_we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    i_re = 1'b1; i_addr = a;
    @(posedge clk); #1 d = o_data;
    @(negedge clk);
    i_re = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] l);
    i_lines = l;
    @(negedge clk);
    i_lines = '0;
  endtask

  logic [15:0] rd;
  int unsigned op, idx;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_int", 16'(o_int), 16'd0);
    check("rst_id", 16'(o_id), 16'd0);
    check("rst_data", o_data, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Edge line 3
    bus_write(BASE + 16'd2, 16'h0008);
    bus_write(BASE, 16'h0008);
    pulse(16'h0008);
    check("edge3_int_k", 16'(o_int), 16'd0);
    @(posedge clk); #1 check("edge3_int_k1", 16'(o_int), 16'd1);
    @(negedge clk);
    bus_read(BASE + 16'd3, rd); check("edge3_claim", rd, 16'd4);
    check("edge3_int_claimed", 16'(o_int), 16'd0);
    bus_read(BASE + 16'd1, rd); check("edge3_pend", rd, 16'd0);
    bus_write(BASE + 16'd4, 16'd4);
    repeat (2) @(posedge clk); #1 check("edge3_int_done", 16'(o_int), 16'd0);
    @(negedge clk);

    // Level line 5
    bus_write(BASE + 16'd2, 16'h0000);
    bus_write(BASE, 16'h0020);
    i_lines = 16'h0020;
    repeat (2) @(posedge clk); #1 check("lvl5_int", 16'(o_int), 16'd1);
    @(negedge clk);
    bus_read(BASE + 16'd3, rd); check("lvl5_claim", rd, 16'd6);
    bus_write(BASE + 16'd4, 16'd6);
    check("lvl5_int_c", 16'(o_int), 16'd0);
    @(posedge clk); #1 check("lvl5_reassert", 16'(o_int), 16'd1);
    @(negedge clk);
    i_lines = '0;
    repeat (2) @(posedge clk); #1 check("lvl5_drop", 16'(o_int), 16'd0);
    @(negedge clk);

    // Lines 2 and 7 together
    bus_write(BASE + 16'd2, 16'h0084);
    bus_write(BASE, 16'h0084);
    pulse(16'h0084);
    @(posedge clk); #1 check("dual_int", 16'(o_int), 16'd1);
    @(negedge clk);
    bus_read(BASE + 16'd3, rd); check("dual_claim1", rd, 16'd3);
    bus_write(BASE + 16'd4, 16'd3);
    @(posedge clk); #1 check("dual_reassert", 16'(o_int), 16'd1);
    @(negedge clk);
    bus_read(BASE + 16'd3, rd); check("dual_claim2", rd, 16'd8);
    bus_write(BASE + 16'd4, 16'd8);

    // Pending while masked, then W1C racing a new edge
    bus_write(BASE, 16'h0000);
    bus_write(BASE + 16'd2, 16'h0002);
    pulse(16'h0002);
    @(negedge clk);
    bus_read(BASE + 16'd1, rd); check("mask_pend", rd, 16'h0002);
    check("mask_int", 16'(o_int), 16'd0);
    bus_write(BASE, 16'h0002);
    @(posedge clk); #1 check("unmask_int", 16'(o_int), 16'd1);
    @(negedge clk);
    i_lines = 16'h0002;
    bus_write(BASE + 16'd1, 16'h0002);
    i_lines = '0;
    bus_read(BASE + 16'd1, rd); check("w1c_set_wins", rd, 16'h0002);
    bus_read(BASE + 16'd3, rd); check("mask_claim", rd, 16'd2);
    bus_write(BASE + 16'd4, 16'd2);

    // Wrong COMPLETE ID, unmapped reads
    bus_write(BASE + 16'd2, 16'h0008);
    bus_write(BASE, 16'h0008);
    pulse(16'h0008);
    @(negedge clk);
    bus_read(BASE + 16'd3, rd); check("wrong_claim", rd, 16'd4);
    bus_write(BASE + 16'd4, 16'd9);
    repeat (3) @(posedge clk); #1 check("wrong_int", 16'(o_int), 16'd0);
    @(negedge clk);
    bus_read(BASE + 16'd3, rd); check("svc_claim_zero", rd, 16'd0);
    bus_read(BASE + 16'd5, rd); check("unmapped_hi", rd, 16'd0);
    bus_read(BASE - 16'd1, rd); check("unmapped_lo", rd, 16'd0);
    bus_read(BASE + 16'd4, rd); check("complete_reads0", rd, 16'd0);
    bus_read(BASE, rd); check("en_before_rst", rd, 16'h0008);

    // Asynchronous reset while in service
    #2 rst_n = 1'b0;
    #1;
    check("arst_int", 16'(o_int), 16'd0);
    check("arst_id", 16'(o_id), 16'd0);
    check("arst_data", o_data, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_read(BASE, rd); check("en_after_rst", rd, 16'd0);

    // Narrow instance masks unused bits
    we4 = 1'b1; addr4 = BASE; data4 = 16'hFFFF;
    @(negedge clk);
    we4 = 1'b0; re4 = 1'b1;
    @(posedge clk); #1 check("n4_enable", odata4, 16'h000F);
    @(negedge clk);
    re4 = 1'b0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      i_lines = i_lines ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      op  = $urandom_range(0, 9);
      idx = $urandom_range(0, 6);
      i_addr = BASE - 16'd1 + 16'(idx);
      i_data = 16'($urandom);
      if (idx == 5 && $urandom_range(0, 1) == 1) i_data = 16'(m_claimed);
      i_we = (op <= 2) || (op == 6);
      i_re = (op >= 3 && op <= 6);
      @(negedge clk);
    end
    i_we = 1'b0; i_re = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
